// File: rtl/fifo_wr_arbiter_if.sv
// Producer-side and FIFO-write-side signals of fifo_wr_arbiter, bundled with master (arbiter) and slave (environment) views.
// wr_count/ovf_count exist only when FIFO_ARB_STATS_EN is defined.
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 8
);
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            gnt;
  logic                          fifo_wr_en;
  logic [DATA_WIDTH-1:0]         fifo_data_in;
  logic                          fifo_full;
  logic                          fifo_wr_ack;
  logic                          fifo_overflow;
  logic                          busy;
  logic                          err_overflow;
  logic                          err_noack;
`ifdef FIFO_ARB_STATS_EN
  logic [CNT_WIDTH-1:0]          wr_count;
  logic [CNT_WIDTH-1:0]          ovf_count;
`else
  // Counter width only matters when the statistics are built in.
  if (CNT_WIDTH < 1) begin : g_cnt_width_invalid
  end
`endif

  modport master (
    input  req, req_data, fifo_full, fifo_wr_ack, fifo_overflow,
    output gnt, fifo_wr_en, fifo_data_in, busy, err_overflow, err_noack
`ifdef FIFO_ARB_STATS_EN
    , output wr_count, ovf_count
`endif
  );

  modport slave (
    output req, req_data, fifo_full, fifo_wr_ack, fifo_overflow,
    input  gnt, fifo_wr_en, fifo_data_in, busy, err_overflow, err_noack
`ifdef FIFO_ARB_STATS_EN
    , input wr_count, ovf_count
`endif
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port; a grant is issued only after the FIFO acknowledges the write.
// Optional saturating write/overflow counters are enabled by defining FIFO_ARB_STATS_EN.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 8
) (
  input logic             clk,
  input logic             rst_n,
  fifo_wr_arbiter_if.master bus
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_ACK,
    ST_DONE
  } state_t;

  state_t                r_state;
  logic [PTR_W-1:0]      r_rr_ptr;
  logic [PTR_W-1:0]      r_sel;
  logic [NUM_REQ-1:0]    r_gnt;
  logic                  r_wr_en;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_err_overflow;
  logic                  r_err_noack;

  logic [PTR_W-1:0]      w_idx [NUM_REQ];
  logic [NUM_REQ-1:0]    w_rot;
  logic [DATA_WIDTH-1:0] w_req_data [NUM_REQ];
  logic                  w_found;
  logic [PTR_W-1:0]      w_pick;
  logic [PTR_W-1:0]      w_sel_next;

  if (NUM_REQ < 2 || NUM_REQ > 8 || CNT_WIDTH < 1) begin : g_param_out_of_range
  end

  // Position gi of the rotated view is requester (rr_ptr + gi) mod NUM_REQ.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rot
    logic [PTR_W:0] w_sum;
    assign w_sum         = {1'b0, r_rr_ptr} + (PTR_W+1)'(gi);
    assign w_idx[gi]     = (w_sum >= (PTR_W+1)'(NUM_REQ)) ? PTR_W'(w_sum - (PTR_W+1)'(NUM_REQ))
                                                          : w_sum[PTR_W-1:0];
    assign w_rot[gi]     = bus.req[w_idx[gi]];
    assign w_req_data[gi] = bus.req_data[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_found = 1'b1;
        w_pick  = w_idx[k];
      end
    end
  end

  assign w_sel_next = (r_sel == PTR_W'(NUM_REQ - 1)) ? '0 : r_sel + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_rr_ptr       <= '0;
      r_sel          <= '0;
      r_gnt          <= '0;
      r_wr_en        <= 1'b0;
      r_data         <= '0;
      r_err_overflow <= 1'b0;
      r_err_noack    <= 1'b0;
    end else begin
      r_gnt <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_found && !bus.fifo_full) begin
            r_sel   <= w_pick;
            r_wr_en <= 1'b1;
            r_data  <= w_req_data[w_pick];
            r_state <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          r_wr_en <= 1'b0;
          r_state <= ST_ACK;
        end
        ST_ACK: begin
          // A rejected write leaves the pointer on the same requester so it is retried first.
          if (bus.fifo_wr_ack) begin
            r_gnt    <= NUM_REQ'(1) << r_sel;
            r_rr_ptr <= w_sel_next;
            r_state  <= ST_DONE;
          end else if (bus.fifo_overflow) begin
            r_err_overflow <= 1'b1;
            r_rr_ptr       <= r_sel;
            r_state        <= ST_IDLE;
          end else begin
            r_err_noack <= 1'b1;
            r_rr_ptr    <= r_sel;
            r_state     <= ST_IDLE;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.gnt          = r_gnt;
  assign bus.fifo_wr_en   = r_wr_en;
  assign bus.fifo_data_in = r_data;
  assign bus.busy         = (r_state != ST_IDLE);
  assign bus.err_overflow = r_err_overflow;
  assign bus.err_noack    = r_err_noack;

`ifdef FIFO_ARB_STATS_EN
  logic [CNT_WIDTH-1:0] r_wr_count;
  logic [CNT_WIDTH-1:0] r_ovf_count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_count  <= '0;
      r_ovf_count <= '0;
    end else if (r_state == ST_ACK) begin
      if (bus.fifo_wr_ack && (r_wr_count != '1)) begin
        r_wr_count <= r_wr_count + 1'b1;
      end
      if (bus.fifo_overflow && (r_ovf_count != '1)) begin
        r_ovf_count <= r_ovf_count + 1'b1;
      end
    end
  end

  assign bus.wr_count  = r_wr_count;
  assign bus.ovf_count = r_ovf_count;
`endif

endmodule
